// File: rtl/float_err_pkg.sv
// float_err_pkg: shared constants, FSM encoding and float helpers for the error monitor.
// Provides FLT_EXP_MAX, FLT_SIGN_BIT, state_t (GET, DIFF, ACC, REPORT),
// ord_map (sign-magnitude float to monotonic unsigned key) and is_nan.
package float_err_pkg;
  localparam logic [7:0] FLT_EXP_MAX = 8'hFF;
  localparam int FLT_SIGN_BIT = 31;
  typedef enum logic [1:0] {GET, DIFF, ACC, REPORT} state_t;
  // -0 folds onto +0 so that a signed-zero disagreement counts as no error
  function automatic logic [31:0] ord_map(input logic [31:0] x);
    logic [31:0] c;
    c = (x == 32'h8000_0000) ? 32'h0 : x;
    return c[FLT_SIGN_BIT] ? ~c : (c | 32'h8000_0000);
  endfunction
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FLT_EXP_MAX) && (x[22:0] != 23'h0);
  endfunction
endpackage

// File: rtl/float_ulp_diff.sv
// float_ulp_diff: combinational ULP distance and NaN flag between two single-precision values.
// Ports: a, b (32-bit floats) in; ulp (|ord(a)-ord(b)|) out; nan (either operand NaN) out.
module float_ulp_diff
  import float_err_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] ulp,
  output logic        nan
);
  logic [31:0] oa, ob;
  assign oa  = ord_map(a);
  assign ob  = ord_map(b);
  assign ulp = (oa > ob) ? oa - ob : ob - oa;
  assign nan = is_nan(a) | is_nan(b);
endmodule

// File: rtl/float_mult_error_monitor.sv
// float_mult_error_monitor: accumulates ULP error statistics between accurate and approximate float results.
// Ports: clk, rst (sync, active-high); input_acc/input_apx with stb/ack handshakes;
// clear (sync statistics clear/abort); statistic outputs sample_count, mismatch_count,
// nan_count, max_ulp_err, sum_ulp_err, over_thresh_count; output_report_stb/ack report handshake.
// Optional macro ERR_THRESH_EN builds the over-threshold counter; otherwise it is tied to 0.
module float_mult_error_monitor
  import float_err_pkg::*;
#(
  parameter int          WINDOW = 5000,
  parameter int          CNT_W  = 16,
  parameter int          SUM_W  = 48,
  parameter logic [31:0] THRESH = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_acc,
  input  logic             input_acc_stb,
  output logic             input_acc_ack,
  input  logic [31:0]      input_apx,
  input  logic             input_apx_stb,
  output logic             input_apx_ack,
  input  logic             clear,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] nan_count,
  output logic [31:0]      max_ulp_err,
  output logic [SUM_W-1:0] sum_ulp_err,
  output logic [CNT_W-1:0] over_thresh_count,
  output logic             output_report_stb,
  input  logic             output_report_ack
);
  state_t state, state_n;
  logic [31:0] acc_q, apx_q, ulp, ulp_q;
  logic nan, nan_q;
  logic have_acc, have_apx, have_acc_n, have_apx_n;
  logic ack_acc_q, ack_apx_q, ack_acc_n, ack_apx_n;
  logic cap_acc, cap_apx, both, last, stat_clr;
  logic [SUM_W:0] sum_ext;
  // acks are registered but masked combinationally so nothing is taken during rst or clear
  assign input_acc_ack     = ack_acc_q & ~clear & ~rst;
  assign input_apx_ack     = ack_apx_q & ~clear & ~rst;
  assign cap_acc           = input_acc_stb & input_acc_ack;
  assign cap_apx           = input_apx_stb & input_apx_ack;
  assign both              = (have_acc | cap_acc) & (have_apx | cap_apx);
  assign last              = sample_count == CNT_W'(WINDOW - 1);
  assign stat_clr          = (state == REPORT) & output_report_ack;
  assign output_report_stb = state == REPORT;
  assign sum_ext           = {1'b0, sum_ulp_err} + {{(SUM_W-31){1'b0}}, ulp_q};
  float_ulp_diff u_diff (
    .a   (acc_q),
    .b   (apx_q),
    .ulp (ulp),
    .nan (nan)
  );
  always_comb begin
    state_n    = state == GET  ? (both ? DIFF : GET) :
                 state == DIFF ? ACC :
                 state == ACC  ? (last ? REPORT : GET) :
                 (output_report_ack ? GET : REPORT);
    have_acc_n = (state == GET) & ~both & (have_acc | cap_acc);
    have_apx_n = (state == GET) & ~both & (have_apx | cap_apx);
    ack_acc_n  = (state_n == GET) & ~have_acc_n;
    ack_apx_n  = (state_n == GET) & ~have_apx_n;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state          <= GET;
      have_acc       <= 1'b0;
      have_apx       <= 1'b0;
      ack_acc_q      <= 1'b0;
      ack_apx_q      <= 1'b0;
      acc_q          <= '0;
      apx_q          <= '0;
      ulp_q          <= '0;
      nan_q          <= 1'b0;
      sample_count   <= '0;
      mismatch_count <= '0;
      nan_count      <= '0;
      max_ulp_err    <= '0;
      sum_ulp_err    <= '0;
    end else begin
      state     <= state_n;
      have_acc  <= have_acc_n;
      have_apx  <= have_apx_n;
      ack_acc_q <= ack_acc_n;
      ack_apx_q <= ack_apx_n;
      if (cap_acc) acc_q <= input_acc;
      if (cap_apx) apx_q <= input_apx;
      if (state == DIFF) begin
        ulp_q <= ulp;
        nan_q <= nan;
      end
      if (state == ACC) begin
        sample_count <= sample_count + CNT_W'(1);
        if (nan_q) nan_count <= nan_count + CNT_W'(1);
        else begin
          mismatch_count <= mismatch_count + CNT_W'(ulp_q != 32'h0);
          max_ulp_err    <= (ulp_q > max_ulp_err) ? ulp_q : max_ulp_err;
          sum_ulp_err    <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        end
      end
      if (stat_clr) begin
        sample_count   <= '0;
        mismatch_count <= '0;
        nan_count      <= '0;
        max_ulp_err    <= '0;
        sum_ulp_err    <= '0;
      end
    end
  end
`ifdef ERR_THRESH_EN
  always_ff @(posedge clk) begin
    if (rst || clear || stat_clr) over_thresh_count <= '0;
    else if (state == ACC && !nan_q && ulp_q > THRESH) over_thresh_count <= over_thresh_count + CNT_W'(1);
  end
`else
  assign over_thresh_count = '0;
`endif
endmodule

// File: tb/tb_float_mult_error_monitor.sv
// tb_float_mult_error_monitor: directed-vector bench with a per-cycle compare against a behavioural statistics model.
module tb_float_mult_error_monitor;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 16;
  localparam int SUM_W  = 48;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] input_acc = 0, input_apx = 0;
  logic input_acc_stb = 0, input_apx_stb = 0, input_acc_ack, input_apx_ack;
  logic clear = 0, output_report_ack = 0, output_report_stb;
  logic [CNT_W-1:0] sample_count, mismatch_count, nan_count, over_thresh_count;
  logic [31:0] max_ulp_err;
  logic [SUM_W-1:0] sum_ulp_err;
  int vectors = 0, misses = 0;
  bit chk_en = 0;
  int m_sc, m_mm, m_nan, m_thr;
  logic [31:0] m_max;
  logic [SUM_W-1:0] m_sum;
  bit e_stb, e_ack;

  always #5 clk = ~clk;

  float_mult_error_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W), .SUM_W(SUM_W), .THRESH(32'd16)) dut (
    .clk(clk), .rst(rst),
    .input_acc(input_acc), .input_acc_stb(input_acc_stb), .input_acc_ack(input_acc_ack),
    .input_apx(input_apx), .input_apx_stb(input_apx_stb), .input_apx_ack(input_apx_ack),
    .clear(clear),
    .sample_count(sample_count), .mismatch_count(mismatch_count), .nan_count(nan_count),
    .max_ulp_err(max_ulp_err), .sum_ulp_err(sum_ulp_err), .over_thresh_count(over_thresh_count),
    .output_report_stb(output_report_stb), .output_report_ack(output_report_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // signed integer position of a float on the ULP line; negatives sit one below their magnitude
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    if (x == 32'h8000_0000) return 0;
    return x[31] ? -m - 1 : m;
  endfunction

  function automatic bit isnan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  function automatic void model_clear();
    m_sc = 0; m_mm = 0; m_nan = 0; m_thr = 0; m_max = 0; m_sum = 0;
    e_stb = 0; e_ack = 1;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b);
    longint d;
    logic [31:0] u;
    d = key(a) - key(b);
    if (d < 0) d = -d;
    u = d[31:0];
    m_sc++;
    if (isnan(a) || isnan(b)) m_nan++;
    else begin
      if (u != 0) m_mm++;
      if (u > m_max) m_max = u;
      m_sum = m_sum + SUM_W'(u);
`ifdef ERR_THRESH_EN
      if (u > 16) m_thr++;
`endif
    end
    if (m_sc == WINDOW) begin e_stb = 1; e_ack = 0; end
  endfunction

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("sample_count", 64'(sample_count), 64'(m_sc));
      chk("mismatch_count", 64'(mismatch_count), 64'(m_mm));
      chk("nan_count", 64'(nan_count), 64'(m_nan));
      chk("max_ulp_err", 64'(max_ulp_err), 64'(m_max));
      chk("sum_ulp_err", 64'(sum_ulp_err), 64'(m_sum));
      chk("over_thresh_count", 64'(over_thresh_count), 64'(m_thr));
      chk("report_stb", 64'(output_report_stb), 64'(e_stb));
      chk("acc_ack", 64'(input_acc_ack), 64'(e_ack));
      chk("apx_ack", 64'(input_apx_ack), 64'(e_ack));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int lead);
    int n = 0, ha = 0, hb = 0;
    chk_en = 0;
    input_acc = a;
    input_apx = b;
    while ((ha == 0 || hb == 0) && n < 50) begin
      input_apx_stb = 1;
      input_acc_stb = n >= lead;
      if (input_acc_stb && input_acc_ack) ha++;
      if (input_apx_stb && input_apx_ack) hb++;
      @(negedge clk);
      n++;
    end
    input_acc_stb = 0;
    input_apx_stb = 0;
    chk("acc_handshakes", 64'(ha), 64'd1);
    chk("apx_handshakes", 64'(hb), 64'd1);
  endtask

  task automatic sample(input logic [31:0] a, input logic [31:0] b, input int lead);
    send(a, b, lead);
    repeat (2) @(negedge clk);
    model(a, b);
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    chk_en = 0;
    clear = 1;
    input_acc = 32'h3f800000;
    input_acc_stb = 1;
    #1;
    chk("ack_in_clear", 64'(input_acc_ack), 64'd0);
    @(negedge clk);
    clear = 0;
    input_acc_stb = 0;
    @(negedge clk);
    model_clear();
    chk_en = 1;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_acc_ack", 64'(input_acc_ack), 64'd0);
    chk("rst_apx_ack", 64'(input_apx_ack), 64'd0);
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_stb", 64'(output_report_stb), 64'd0);
    rst = 0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    sample(32'h3f99999a, 32'h3f99999a, 0);
    chk("t1_sample", 64'(sample_count), 64'd1);
    chk("t1_mismatch", 64'(mismatch_count), 64'd0);
    sample(32'h40000000, 32'h40000001, 0);
    chk("t2_max", 64'(max_ulp_err), 64'd1);
    chk("t2_sum", 64'(sum_ulp_err), 64'd1);
    chk("t2_mismatch", 64'(mismatch_count), 64'd1);
    sample(32'h00000000, 32'h80000000, 0);
    chk("t3_mismatch", 64'(mismatch_count), 64'd1);
    sample(32'h3f800000, 32'hbf800000, 0);
    chk("t4_max", 64'(max_ulp_err), 64'h7F000001);
    chk("t4_stb", 64'(output_report_stb), 64'd1);
    repeat (3) @(negedge clk);
    chk_en = 0;
    output_report_ack = 1;
    @(negedge clk);
    output_report_ack = 0;
    model_clear();
    chk_en = 1;
    @(negedge clk);
    sample(32'h7fc00000, 32'h3f800000, 4);
    chk("t5_nan", 64'(nan_count), 64'd1);
    chk("t5_sample", 64'(sample_count), 64'd1);
    chk("t5_sum", 64'(sum_ulp_err), 64'd0);
    pulse_clear();
    sample(32'h40000000, 32'h40000001, 0);
    sample(32'h40000000, 32'h40000002, 1);
    sample(32'h3f800003, 32'h3f800000, 0);
    sample(32'h3f800000, 32'h3f800000, 0);
    repeat (10) @(negedge clk);
    chk("w_sum", 64'(sum_ulp_err), 64'd6);
    chk("w_max", 64'(max_ulp_err), 64'd3);
    chk("w_mismatch", 64'(mismatch_count), 64'd3);
    chk("w_stb", 64'(output_report_stb), 64'd1);
    chk("w_ack", 64'(input_apx_ack), 64'd0);
    chk_en = 0;
    output_report_ack = 1;
    @(negedge clk);
    output_report_ack = 0;
    model_clear();
    chk_en = 1;
    @(negedge clk);
    chk("w_after_ack", 64'(sample_count), 64'd0);
    sample(32'h40000000, 32'h40000011, 0);
`ifdef ERR_THRESH_EN
    chk("thr_count", 64'(over_thresh_count), 64'd1);
`endif
    sample(32'h7f800000, 32'h7f7fffff, 0);
    sample(32'hff800000, 32'h7f800000, 0);
    chk("inf_max", 64'(max_ulp_err), 64'hFF000001);
    sample(32'h00000000, 32'h00000000, 0);
    repeat (2) @(negedge clk);
    pulse_clear();
    chk("clr_stb", 64'(output_report_stb), 64'd0);
    chk("clr_sum", 64'(sum_ulp_err), 64'd0);
    chk_en = 0;
    input_apx = 32'h40000000;
    input_apx_stb = 1;
    @(negedge clk);
    input_apx_stb = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    model_clear();
    sample(32'h40000000, 32'h40000005, 0);
    chk("rst_mid_sum", 64'(sum_ulp_err), 64'd5);
    chk("rst_mid_sample", 64'(sample_count), 64'd1);
    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
